// File: rtl/jelly_wishbone_arbiter_rr.sv
// rtl/jelly_wishbone_arbiter_rr.sv - round-robin arbiter sharing one wishbone slave among NUM masters
// Optional watchdog: define JELLY_WB_ARBITER_TIMEOUT_EN to enable the TIMEOUT-cycle bus watchdog.
module jelly_wishbone_arbiter_rr #(
  parameter int NUM       = 4,
  parameter int ADR_WIDTH = 12,
  parameter int DAT_SIZE  = 2,
  parameter int DAT_WIDTH = (8 << DAT_SIZE),
  parameter int SEL_WIDTH = (1 << DAT_SIZE),
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM*ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [NUM*DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [DAT_WIDTH-1:0]     s_wb_dat_o,
  input  logic [NUM-1:0]           s_wb_we_i,
  input  logic [NUM*SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic [NUM-1:0]           s_wb_stb_i,
  output logic [NUM-1:0]           s_wb_ack_o,
  output logic [ADR_WIDTH-1:0]     m_wb_adr_o,
  output logic [DAT_WIDTH-1:0]     m_wb_dat_o,
  input  logic [DAT_WIDTH-1:0]     m_wb_dat_i,
  output logic                     m_wb_we_o,
  output logic [SEL_WIDTH-1:0]     m_wb_sel_o,
  output logic                     m_wb_stb_o,
  input  logic                     m_wb_ack_i,
  output logic [NUM-1:0]           grant_o,
  output logic                     timeout_o
);

  localparam int IW = $clog2(NUM);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;
  logic          done;

`ifdef JELLY_WB_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
`ifdef JELLY_WB_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef JELLY_WB_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // First requester at or above the pointer, wrapping modulo NUM.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM)) cand = cand - (IW+1)'(NUM);
      if (!found && s_wb_stb_i[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    done       = 1'b0;
    s_wb_ack_o = '0;
    s_wb_dat_o = m_wb_dat_i;
    grant_o    = '0;
    timeout_o  = 1'b0;
    m_wb_stb_o = 1'b0;
`ifdef JELLY_WB_ARBITER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    // grant_q is held at 0 while idle, so the shared fields follow master 0 then.
    m_wb_adr_o = s_wb_adr_i[0 +: ADR_WIDTH];
    m_wb_dat_o = s_wb_dat_i[0 +: DAT_WIDTH];
    m_wb_we_o  = s_wb_we_i[0];
    m_wb_sel_o = s_wb_sel_i[0 +: SEL_WIDTH];
    for (int k = 1; k < NUM; k++) begin
      if (grant_q == IW'(k)) begin
        m_wb_adr_o = s_wb_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
        m_wb_dat_o = s_wb_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
        m_wb_we_o  = s_wb_we_i[k];
        m_wb_sel_o = s_wb_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick;
`ifdef JELLY_WB_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        grant_o[grant_q] = 1'b1;
        m_wb_stb_o       = s_wb_stb_i[grant_q];
        if (m_wb_stb_o && m_wb_ack_i) begin
          s_wb_ack_o[grant_q] = 1'b1;
          done                = 1'b1;
        end else if (!m_wb_stb_o) begin
          // Master withdrew its request: abort silently, rotate as if served.
          done = 1'b1;
        end
`ifdef JELLY_WB_ARBITER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT)) begin
          s_wb_ack_o[grant_q] = 1'b1;
          s_wb_dat_o          = '0;
          timeout_o           = 1'b1;
          done                = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (grant_q == IW'(NUM-1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jelly_wishbone_arbiter_rr.sv
// tb/tb_jelly_wishbone_arbiter_rr.sv - directed vector bench for jelly_wishbone_arbiter_rr
module tb_jelly_wishbone_arbiter_rr;

  localparam int NUM = 4;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int SW  = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NUM*AW-1:0] s_adr;
  logic [NUM*DW-1:0] s_dat;
  logic [DW-1:0]   s_dat_o;
  logic [NUM-1:0]  s_we;
  logic [NUM*SW-1:0] s_sel;
  logic [NUM-1:0]  s_stb;
  logic [NUM-1:0]  s_ack;
  logic [AW-1:0]   m_adr;
  logic [DW-1:0]   m_dat_o;
  logic [DW-1:0]   m_dat_i;
  logic            m_we;
  logic [SW-1:0]   m_sel;
  logic            m_stb;
  logic            m_ack;
  logic [NUM-1:0]  grant;
  logic            timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jelly_wishbone_arbiter_rr #(.NUM(NUM), .ADR_WIDTH(AW), .DAT_SIZE(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_wb_adr_i(s_adr), .s_wb_dat_i(s_dat), .s_wb_dat_o(s_dat_o),
    .s_wb_we_i(s_we), .s_wb_sel_i(s_sel), .s_wb_stb_i(s_stb), .s_wb_ack_o(s_ack),
    .m_wb_adr_o(m_adr), .m_wb_dat_o(m_dat_o), .m_wb_dat_i(m_dat_i),
    .m_wb_we_o(m_we), .m_wb_sel_o(m_sel), .m_wb_stb_o(m_stb), .m_wb_ack_i(m_ack),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  stb;
    logic        ack;
    logic [3:0]  exp_grant;
    logic        exp_mstb;
    logic [3:0]  exp_ack;
    logic [11:0] exp_adr;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // Each row is one clock: inputs driven after negedge, outputs checked before the next posedge.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 12'h100};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 12'h100};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 12'h100};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 12'h101};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 12'h100};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 12'h102};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 12'h100};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 12'h103};
    vecs[8]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 4'b0000, 12'h100};
    vecs[9]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 4'b0010, 12'h101};
    vecs[10] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 4'b0000, 12'h100};
    vecs[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 4'b1000, 12'h103};
    vecs[12] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 12'h100};
    vecs[13] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000, 12'h100};
    vecs[14] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 12'h100};
    vecs[15] = '{4'b0011, 1'b1, 4'b0000, 1'b0, 4'b0000, 12'h100};
    vecs[16] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 4'b0010, 12'h101};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 12'h100};
    vecs[18] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 12'h100};

    for (int k = 0; k < NUM; k++) begin
      s_adr[k*AW +: AW] = 12'h100 + 12'(k);
      s_dat[k*DW +: DW] = 32'hA000_0000 + 32'(k);
      s_we[k]           = k[0];
      s_sel[k*SW +: SW] = 4'b0001 << k;
    end
    s_stb   = '0;
    m_ack   = 1'b0;
    m_dat_i = 32'h5555_AAAA;

    #12;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_mstb", 32'(m_stb), 32'h0);
    check("reset_ack", 32'(s_ack), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      s_stb = vecs[i].stb;
      m_ack = vecs[i].ack;
      #1;
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("v%0d_mstb", i), 32'(m_stb), 32'(vecs[i].exp_mstb));
      check($sformatf("v%0d_ack", i), 32'(s_ack), 32'(vecs[i].exp_ack));
      check($sformatf("v%0d_adr", i), 32'(m_adr), 32'(vecs[i].exp_adr));
      check($sformatf("v%0d_timeout", i), 32'(timeout), 32'h0);
      @(negedge clk);
    end

    // Single write from master 2, slave inserts two wait states.
    s_adr[2*AW +: AW] = 12'h010;
    s_dat[2*DW +: DW] = 32'h1234_5678;
    s_sel[2*SW +: SW] = 4'hf;
    s_we[2]           = 1'b1;
    s_stb             = 4'b0100;
    m_ack             = 1'b0;
    #1;
    check("wr_stb_before", 32'(m_stb), 32'h0);
    @(negedge clk);
    check("wr_stb_after", 32'(m_stb), 32'h1);
    check("wr_adr", 32'(m_adr), 32'h010);
    check("wr_dat", m_dat_o, 32'h1234_5678);
    check("wr_sel", 32'(m_sel), 32'hf);
    check("wr_we", 32'(m_we), 32'h1);
    for (int w = 0; w < 3; w++) begin
      m_ack = (w == 2);
      #1;
      check($sformatf("wr_ack_w%0d", w), 32'(s_ack), (w == 2) ? 32'h4 : 32'h0);
      @(negedge clk);
    end
    s_stb = '0;
    m_ack = 1'b0;
    #1;
    check("wr_grant_after", 32'(grant), 32'h0);
    check("wr_ack_after", 32'(s_ack), 32'h0);

    // Read from master 0 with data returned alongside ack.
    @(negedge clk);
    s_adr[0 +: AW] = 12'h004;
    s_we[0]        = 1'b0;
    s_stb          = 4'b0001;
    @(negedge clk);
    m_dat_i = 32'hCAFE_F00D;
    m_ack   = 1'b1;
    #1;
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_adr", 32'(m_adr), 32'h004);
    check("rd_we", 32'(m_we), 32'h0);
    check("rd_ack", 32'(s_ack), 32'h1);
    check("rd_dat", s_dat_o, 32'hCAFE_F00D);
    @(negedge clk);
    s_stb = '0;
    m_ack = 1'b0;

    // Asynchronous reset while master 1 holds the bus.
    @(negedge clk);
    s_stb = 4'b0010;
    @(negedge clk);
    check("rst_pre_grant", 32'(grant), 32'h2);
    check("rst_pre_mstb", 32'(m_stb), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_grant", 32'(grant), 32'h0);
    check("rst_async_mstb", 32'(m_stb), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    s_stb   = 4'b1111;
    @(negedge clk);
    check("rst_ptr0_grant", 32'(grant), 32'h1);
    s_stb = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jelly_wishbone_arbiter_rr.md
Name: jelly_wishbone_arbiter_rr

Overview:
Round-robin arbiter that shares one wishbone-style slave bus (stb/ack, no cyc) among NUM requesting masters. It sits between bus masters (CPU, DMA, bench master models) and a single slave port. Grant is registered and held for exactly one transaction, from stb until ack. Priority rotates after every completed transfer.

Parameters:
NUM, 4, number of requesting masters (2..16)
ADR_WIDTH, 12, address width
DAT_SIZE, 2, data width exponent (0:8bit, 1:16bit, 2:32bit ...)
DAT_WIDTH, (8 << DAT_SIZE), data width
SEL_WIDTH, (1 << DAT_SIZE), byte-select width
TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
s_wb_adr_i  input  NUM*ADR_WIDTH  per-master address, master k at [k*ADR_WIDTH +: ADR_WIDTH]
s_wb_dat_i  input  NUM*DAT_WIDTH  per-master write data
s_wb_dat_o  output  DAT_WIDTH  read data, broadcast to all masters
s_wb_we_i  input  NUM  per-master write enable
s_wb_sel_i  input  NUM*SEL_WIDTH  per-master byte select
s_wb_stb_i  input  NUM  per-master strobe (request)
s_wb_ack_o  output  NUM  per-master ack, one-hot or zero
m_wb_adr_o  output  ADR_WIDTH  shared slave address
m_wb_dat_o  output  DAT_WIDTH  shared slave write data
m_wb_dat_i  input  DAT_WIDTH  slave read data
m_wb_we_o  output  1  shared write enable
m_wb_sel_o  output  SEL_WIDTH  shared byte select
m_wb_stb_o  output  1  shared strobe
m_wb_ack_i  input  1  slave ack
grant_o  output  NUM  one-hot current grant (debug/monitor)
timeout_o  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, grant 0, priority pointer 0 (master 0 highest), timeout_o 0; hence m_wb_stb_o 0, s_wb_ack_o 0.
- States: IDLE, BUSY.
- IDLE: if any s_wb_stb_i set, register grant to first requester scanning from pointer upward modulo NUM; next state BUSY. No requests: stay IDLE.
- BUSY: m_wb_adr/dat/we/sel driven combinationally from granted master; m_wb_stb_o = s_wb_stb_i[grant]. s_wb_ack_o[grant] = m_wb_ack_i; other acks 0. s_wb_dat_o = m_wb_dat_i unconditionally.
- In IDLE m_wb_stb_o 0; m_wb_adr/dat/we/sel follow master 0 (don't care).
- Completion: m_wb_stb_o & m_wb_ack_i in BUSY -> state IDLE, grant cleared, pointer <= (grant index + 1) mod NUM.
- Latency: request to m_wb_stb_o = 1 cycle; minimum period per transfer = 2 cycles + slave wait states (one IDLE cycle between transfers, intentional).
- Masters hold stb until ack. Granted master dropping stb in BUSY without ack: abort, return IDLE, pointer advances as if completed, no ack issued.
- Non-granted masters may raise/drop stb freely; they are never acked.
- Ack arriving with m_wb_stb_o low is ignored.
- Reset mid-transfer: immediate return to IDLE; in-flight slave ack lost by design.
- Starvation-free: each requester waits at most NUM-1 transfers.

Optional Feature:
JELLY_WB_ARBITER_TIMEOUT_EN
- Defined: counter cleared on entry to BUSY, incremented each BUSY cycle without ack; at count == TIMEOUT, arbiter drives s_wb_ack_o[grant] high for one cycle with s_wb_dat_o forced 0, pulses timeout_o, returns to IDLE, advances pointer. Counter width $clog2(TIMEOUT+1).
- Not defined: no counter; BUSY waits for ack indefinitely; timeout_o tied 0.

Test Plan:
- Single master 2 writes adr 0x010 dat 0x12345678 sel 4'hf, slave acks after 2 waits -> m_wb_stb_o rises 1 cycle after s_wb_stb_i[2], fields match, s_wb_ack_o = 4'b0100 for one cycle, grant_o 0 afterwards.
- All 4 masters request continuously, slave acks immediately -> grant order 0,1,2,3,0 with one IDLE cycle between each.
- Masters 1 and 3 request after master 3 just completed -> master 1 (pointer 0 skips idle 0) granted first, then 3.
- Read: master 0 reads adr 0x004, slave returns 0xCAFEF00D with ack -> s_wb_dat_o = 0xCAFEF00D during s_wb_ack_o[0]; other acks remain 0.
- reset_n low mid-BUSY with master 1 granted -> m_wb_stb_o and grant_o 0 asynchronously; after release, pointer 0.
- With JELLY_WB_ARBITER_TIMEOUT_EN, TIMEOUT=8, slave never acks -> after 8 BUSY cycles ack to requester with data 0, timeout_o pulse, next requester served.
